// File: rtl/logicnet_lut_layer_pipe.sv
// Runtime-programmable LogicNet layer: NEURONS truth tables evaluated in a 2-stage valid/ready pipeline.
// Optional macro LUT_PARITY_EN adds per-entry even parity with a sticky parity_err output.
module logicnet_lut_layer_pipe #(
  parameter  int unsigned NEURONS   = 4,
  parameter  int unsigned ADDR_BITS = 6,
  parameter  int unsigned OUT_BITS  = 2,
  localparam int unsigned NW        = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_start,
  input  logic                          cfg_we,
  input  logic [NW-1:0]                 cfg_neuron,
  input  logic [ADDR_BITS-1:0]          cfg_addr,
  input  logic [OUT_BITS-1:0]           cfg_data,
  input  logic                          cfg_done,
  output logic                          cfg_err,
  output logic                          mode_run,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NEURONS*ADDR_BITS-1:0]  in_addr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NEURONS*OUT_BITS-1:0]   out_data
`ifdef LUT_PARITY_EN
  ,
  input  logic                          cfg_parity_flip,
  output logic                          parity_err
`endif
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
`ifdef LUT_PARITY_EN
  localparam int unsigned EW = OUT_BITS + 1;
`else
  localparam int unsigned EW = OUT_BITS;
`endif

  typedef enum logic [1:0] {ST_CFG, ST_RUN, ST_DRAIN} state_t;

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic                           r_s1_valid;
  logic [NEURONS*ADDR_BITS-1:0]   r_s1_addr;
  logic                           r_out_valid;
  logic [NEURONS*OUT_BITS-1:0]    r_out_data;
  logic                           r_cfg_err;
  logic                           r_mode_run;
  logic                           w_adv;
  logic                           w_s1_move;
  logic                           w_in_ready;
  logic                           w_accept;
  logic                           w_neuron_ok;
  logic                           w_wr_ok;
  logic                           w_wr_bad;
  logic [EW-1:0]                  w_wdata;
  logic [NEURONS*OUT_BITS-1:0]    w_rd_data;
  logic [EW-1:0]                  r_mem [NEURONS][DEPTH];
  logic [EW-1:0]                  w_rd  [NEURONS];
`ifdef LUT_PARITY_EN
  logic                           r_parity_err;
  logic                           w_par_bad;
`endif

  // Handshake: stage 2 moves when empty or drained; stage 1 moves when empty or stage 2 moves.
  assign w_adv      = !r_out_valid || out_ready;
  assign w_s1_move  = !r_s1_valid || w_adv;
  assign w_in_ready = (r_state == ST_RUN) && w_s1_move;
  assign w_accept   = in_valid && w_in_ready;

  assign w_neuron_ok = ({1'b0, cfg_neuron} < (NW+1)'(NEURONS));
  assign w_wr_ok     = cfg_we && (r_state == ST_CFG) && w_neuron_ok;
  assign w_wr_bad    = cfg_we && !w_wr_ok;

`ifdef LUT_PARITY_EN
  assign w_wdata = {(^cfg_data) ^ cfg_parity_flip, cfg_data};
`else
  assign w_wdata = cfg_data;
`endif

  // Table storage is intentionally not reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[cfg_neuron][cfg_addr] <= w_wdata;
  end

  for (genvar n = 0; n < NEURONS; n++) begin : g_rd
    assign w_rd[n] = r_mem[n][r_s1_addr[n*ADDR_BITS +: ADDR_BITS]];
  end

  always_comb begin
    w_rd_data = '0;
`ifdef LUT_PARITY_EN
    w_par_bad = 1'b0;
`endif
    for (int n = 0; n < NEURONS; n++) begin
      w_rd_data[n*OUT_BITS +: OUT_BITS] = w_rd[n][OUT_BITS-1:0];
`ifdef LUT_PARITY_EN
      w_par_bad = w_par_bad | (^w_rd[n]);
`endif
    end
  end

  // Next-state: cfg_done wins in CFG, cfg_start wins in RUN by construction.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CFG:   if (cfg_done) w_state_nxt = ST_RUN;
      ST_RUN:   if (cfg_start) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (!r_s1_valid && !r_out_valid) w_state_nxt = ST_CFG;
      default:  w_state_nxt = ST_CFG;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_CFG;
      r_mode_run   <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_s1_valid   <= 1'b0;
      r_s1_addr    <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
`ifdef LUT_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_mode_run <= (w_state_nxt == ST_RUN);
      r_cfg_err  <= r_cfg_err | w_wr_bad;
      if (w_s1_move) begin
        r_s1_valid <= w_accept;
        if (w_accept) r_s1_addr <= in_addr;
      end
      if (w_adv) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_data <= w_rd_data;
`ifdef LUT_PARITY_EN
          r_parity_err <= r_parity_err | w_par_bad;
`endif
        end
      end
    end
  end

  assign cfg_err   = r_cfg_err;
  assign mode_run  = r_mode_run;
  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
`ifdef LUT_PARITY_EN
  assign parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_logicnet_lut_layer_pipe.sv
// Directed, table-driven bench for logicnet_lut_layer_pipe (4 neurons, 6-bit addresses, 2-bit outputs).
module tb_logicnet_lut_layer_pipe;

  logic        clk;
  logic        rst;
  logic        cfg_start, cfg_we, cfg_done;
  logic [1:0]  cfg_neuron;
  logic [5:0]  cfg_addr;
  logic [1:0]  cfg_data;
  logic        cfg_err, mode_run;
  logic        in_valid, in_ready;
  logic [23:0] in_addr;
  logic        out_valid, out_ready;
  logic [7:0]  out_data;
`ifdef LUT_PARITY_EN
  logic        cfg_parity_flip;
  logic        parity_err;
`endif

  logicnet_lut_layer_pipe dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_we(cfg_we), .cfg_neuron(cfg_neuron),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_done(cfg_done),
    .cfg_err(cfg_err), .mode_run(mode_run),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef LUT_PARITY_EN
    , .cfg_parity_flip(cfg_parity_flip), .parity_err(parity_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] addr;
    logic [7:0]  exp;
  } vec_t;

  vec_t       vt [8];
  int         n_cmp = 0;
  int         n_err = 0;
  int         n_pop = 0;
  logic       last_acc;
  logic [7:0] cur_exp;
  logic [7:0] held;
  logic [7:0] exp_q [$];

  function automatic logic [23:0] pa(int a0, int a1, int a2, int a3);
    return {6'(a3), 6'(a2), 6'(a1), 6'(a0)};
  endfunction

  function automatic logic [7:0] po(int o0, int o1, int o2, int o3);
    return {2'(o3), 2'(o2), 2'(o1), 2'(o0)};
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  // One clock: record handshakes into the scoreboard, then step past the edge.
  task automatic cyc();
    #1;
    last_acc = in_valid && in_ready;
    if (last_acc) exp_q.push_back(cur_exp);
    if (out_valid && out_ready) begin
      n_pop++;
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL spurious_output: got %h want none", out_data);
      end else begin
        check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wr(int n, int a, int d);
    cfg_we = 1'b1; cfg_neuron = 2'(n); cfg_addr = 6'(a); cfg_data = 2'(d);
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic send(vec_t v);
    in_valid = 1'b1; in_addr = v.addr; cur_exp = v.exp;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic drain(string name);
    for (int k = 0; k < 30 && exp_q.size() != 0; k++) cyc();
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    // Table pattern (a+n)&3, with n0/a32=2 and n1/a8=3 overridden.
    vt[0] = '{pa(32, 8, 0, 0),   po(2, 3, 2, 3)};
    vt[1] = '{pa(1, 2, 3, 4),    po(1, 3, 1, 3)};
    vt[2] = '{pa(5, 5, 5, 5),    po(1, 2, 3, 0)};
    vt[3] = '{pa(63, 62, 61, 60), po(3, 3, 3, 3)};
    vt[4] = '{pa(10, 20, 30, 40), po(2, 1, 0, 3)};
    vt[5] = '{pa(0, 0, 0, 0),    po(0, 1, 2, 3)};
    vt[6] = '{pa(7, 11, 13, 17), po(3, 0, 3, 0)};
    vt[7] = '{pa(33, 9, 8, 2),   po(1, 2, 2, 1)};

    rst = 1'b1; cfg_start = 0; cfg_we = 0; cfg_done = 0; cfg_neuron = 0;
    cfg_addr = 0; cfg_data = 0; in_valid = 0; in_addr = 0; out_ready = 0;
    cur_exp = 0; held = 0;
`ifdef LUT_PARITY_EN
    cfg_parity_flip = 0;
`endif
    #12;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_mode_run", 32'(mode_run), 0);
    check("rst_cfg_err", 32'(cfg_err), 0);
    @(posedge clk); #1; rst = 1'b0;

    for (int n = 0; n < 4; n++)
      for (int a = 0; a < 64; a++) wr(n, a, (a + n) & 3);
    wr(0, 32, 2);
    wr(1, 8, 3);
    check("cfg_err_after_prog", 32'(cfg_err), 0);
    check("cfg_in_ready", 32'(in_ready), 0);

    // Simultaneous start+done in CFG: done wins.
    cfg_start = 1; cfg_done = 1; cyc(); cfg_start = 0; cfg_done = 0;
    check("run_mode_run", 32'(mode_run), 1);

    // Two-cycle latency.
    out_ready = 1;
    in_valid = 1; in_addr = vt[0].addr; cur_exp = vt[0].exp;
    #1 check("lat_in_ready", 32'(in_ready), 1);
    cyc(); in_valid = 0;
    check("lat_valid_c1", 32'(out_valid), 0);
    cyc();
    check("lat_valid_c2", 32'(out_valid), 1);
    check("lat_data", 32'(out_data), 32'(vt[0].exp));
    drain("lat_drain");

    // Back-to-back stream at full throughput.
    n_pop = 0;
    for (int c = 0; c < 9; c++) begin
      if (c < 8) begin
        in_valid = 1; in_addr = vt[c].addr; cur_exp = vt[c].exp;
        #1 check("stream_in_ready", 32'(in_ready), 1);
      end else in_valid = 0;
      cyc();
      if (c >= 1) check("stream_out_valid", 32'(out_valid), 1);
    end
    in_valid = 0;
    drain("stream_drain");
    check("stream_count", 32'(n_pop), 8);

    // Downstream stall of 5 cycles mid-stream.
    begin
      int i;
      i = 0; n_pop = 0;
      for (int c = 0; c < 40 && (i < 8 || exp_q.size() != 0); c++) begin
        out_ready = !(c >= 3 && c < 8);
        in_valid  = (i < 8);
        if (i < 8) begin in_addr = vt[i].addr; cur_exp = vt[i].exp; end
        #1;
        if (c >= 3 && c < 8) begin
          if (c == 3) held = out_data;
          check("stall_out_valid", 32'(out_valid), 1);
          check("stall_held", 32'(out_data), 32'(held));
          check("stall_in_ready", 32'(in_ready), 0);
        end
        cyc();
        if (last_acc) i++;
      end
      in_valid = 0; out_ready = 1;
      check("stall_count", 32'(n_pop), 8);
      check("stall_q_empty", 32'(exp_q.size()), 0);
    end

    // Write while running is dropped and flags cfg_err.
    wr(0, 6, 1);
    check("run_wr_err", 32'(cfg_err), 1);
    send('{pa(6, 0, 0, 0), po(2, 1, 2, 3)});
    drain("run_wr_readback");
    check("run_wr_err_sticky", 32'(cfg_err), 1);

    // Drain with two vectors in flight and downstream stalled.
    out_ready = 0;
    send(vt[1]);
    send(vt[2]);
    cfg_start = 1; cfg_done = 1; cyc(); cfg_start = 0; cfg_done = 0;
    check("drain_mode_run", 32'(mode_run), 0);
    cfg_done = 1; cyc(); cfg_done = 0;
    check("drain_done_ignored", 32'(mode_run), 0);
    check("drain_hold_valid", 32'(out_valid), 1);
    out_ready = 1;
    #1 check("drain_in_ready", 32'(in_ready), 0);
    n_pop = 0;
    for (int k = 0; k < 10 && out_valid; k++) cyc();
    check("drain_delivered", 32'(n_pop), 2);
    check("drain_q_empty", 32'(exp_q.size()), 0);
    cyc();
    check("cfg_mode_run", 32'(mode_run), 0);
    cfg_done = 1; cyc(); cfg_done = 0;
    check("back_to_run", 32'(mode_run), 1);

    // Asynchronous reset with a result pending.
    out_ready = 0;
    send(vt[4]);
    cyc();
    check("pre_rst_valid", 32'(out_valid), 1);
    #1 rst = 1;
    #1;
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_in_ready", 32'(in_ready), 0);
    check("arst_mode_run", 32'(mode_run), 0);
    check("arst_cfg_err", 32'(cfg_err), 0);
    #1 rst = 0;
    exp_q.delete();
    cfg_done = 1; cyc(); cfg_done = 0;
    check("arst_run", 32'(mode_run), 1);
    out_ready = 1;
    send(vt[0]);
    send(vt[3]);
    drain("arst_retained");

`ifdef LUT_PARITY_EN
    cfg_start = 1; cyc(); cfg_start = 0;
    cyc(); cyc();
    cfg_parity_flip = 1; wr(2, 0, 2); cfg_parity_flip = 0;
    check("par_clean", 32'(parity_err), 0);
    cfg_done = 1; cyc(); cfg_done = 0;
    send(vt[5]);
    cyc();
    check("par_valid", 32'(out_valid), 1);
    check("par_err", 32'(parity_err), 1);
    drain("par_drain");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
